// File: rtl/sccb_reader.sv
// SCCB read-back master for the OV7670: writes the sub-address, then reads one
// register byte back. SCL is push-pull and SDA is open-drain through sda_oe.
module sccb_reader #(
  parameter int         QUARTER = 63,
  parameter logic [7:0] DEV_ID  = 8'h42
) (
  input  logic       clk_25M,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] reg_addr,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       scl,
  output logic       ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       ack_err
);

  typedef enum logic [3:0] {
    IDLE, START1, TX_IDW, TX_ADDR, STOP1, BUS_FREE, START2, TX_IDR, RX_DATA, STOP2
  } state_t;

  localparam logic [7:0] QLAST = 8'(QUARTER - 1);

  state_t     state, state_n;
  logic [7:0] qcnt, qcnt_n;
  logic [1:0] qtr, qtr_n;
  logic [3:0] bit_cnt, bit_n;
  logic [1:0] last_q;
  logic [7:0] addr, shreg, tx_byte;
  logic       scl_n, oe_n;
  logic       tick, accept, is_byte, sample, done;

  assign tick    = (state != IDLE) && (qcnt == QLAST);
  assign accept  = (state == IDLE) && start;
  assign is_byte = state inside {TX_IDW, TX_ADDR, TX_IDR, RX_DATA};
  assign sample  = tick && is_byte && (qtr == 2'd2);
  assign done    = tick && (state == STOP2) && (qtr == 2'd2);

  // SCL/SDA are registered from the next-state decode so the pins never glitch.
  always_ff @(posedge clk_25M) begin
    if (rst) begin
      state   <= IDLE;
      qcnt    <= '0;
      qtr     <= '0;
      bit_cnt <= '0;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
    end else begin
      state   <= state_n;
      qcnt    <= qcnt_n;
      qtr     <= qtr_n;
      bit_cnt <= bit_n;
      scl     <= scl_n;
      sda_oe  <= oe_n;
    end
  end

  always_comb begin
    state_n = state;
    qcnt_n  = qcnt;
    qtr_n   = qtr;
    bit_n   = bit_cnt;
    case (state)
      START1, START2: last_q = 2'd1;
      STOP1, STOP2:   last_q = 2'd2;
      default:        last_q = 2'd3;
    endcase
    if (state == IDLE) begin
      qcnt_n = '0;
      if (start) begin
        state_n = START1;
        qtr_n   = '0;
        bit_n   = '0;
      end
    end else if (!tick) begin
      qcnt_n = qcnt + 8'd1;
    end else begin
      qcnt_n = '0;
      if (qtr != last_q) begin
        qtr_n = qtr + 2'd1;
      end else begin
        qtr_n = '0;
        if (is_byte && (bit_cnt != 4'd8)) begin
          bit_n = bit_cnt + 4'd1;
        end else begin
          bit_n = '0;
          case (state)
            START1:   state_n = TX_IDW;
            TX_IDW:   state_n = TX_ADDR;
            TX_ADDR:  state_n = STOP1;
            STOP1:    state_n = BUS_FREE;
            BUS_FREE: state_n = START2;
            START2:   state_n = TX_IDR;
            TX_IDR:   state_n = RX_DATA;
            RX_DATA:  state_n = STOP2;
            default:  state_n = IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    ready   = (state == IDLE);
    scl_n   = 1'b1;
    oe_n    = 1'b0;
    tx_byte = DEV_ID;
    case (state_n)
      TX_ADDR: tx_byte = addr;
      TX_IDR:  tx_byte = DEV_ID | 8'h01;
      default: tx_byte = DEV_ID;
    endcase
    case (state_n)
      START1, START2: oe_n = (qtr_n == 2'd1);
      TX_IDW, TX_ADDR, TX_IDR, RX_DATA: begin
        scl_n = qtr_n[1];
        if ((state_n != RX_DATA) && (bit_n != 4'd8))
          oe_n = ~tx_byte[3'd7 - bit_n[2:0]];
      end
      STOP1, STOP2: begin
        scl_n = (qtr_n != 2'd0);
        oe_n  = (qtr_n != 2'd2);
      end
      default: ;
    endcase
  end

  // Sampling happens on the last cycle of q2, while SCL has been high for a quarter.
  always_ff @(posedge clk_25M) begin
    if (rst) begin
      addr     <= '0;
      shreg    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      rd_valid <= done;
      if (accept) begin
        addr    <= reg_addr;
        ack_err <= 1'b0;
      end
      if (sample) begin
        if (state == RX_DATA) begin
          if (bit_cnt != 4'd8)
            shreg <= {shreg[6:0], sda_i};
        end else if ((bit_cnt == 4'd8) && sda_i) begin
          ack_err <= 1'b1;
        end
      end
      if (done)
        rd_data <= shreg;
    end
  end

endmodule

// File: tb/tb_sccb_reader.sv
// Bench for sccb_reader: a protocol-level SCCB slave model decodes the bus and
// answers reads from a random register file; a second instance checks default timing.
module tb_sccb_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start63;
  logic [7:0] reg_addr, reg_addr63;
  logic       sda_oe, scl, ready, rd_valid, ack_err;
  logic [7:0] rd_data;
  logic       sda_oe63, scl63, ready63, rd_valid63, ack_err63;
  logic [7:0] rd_data63;
  logic       resp_rel, rel63;
  logic       sda_line, sda_line63;

  int total = 0;
  int bad   = 0;

  logic [7:0] reg_file [256];
  logic [7:0] got [$];
  int         n_start, n_stop, nack_idx;
  int         bit_pos, byte_in_frame;
  bit         frame_read;
  logic [7:0] cur_byte, last_addr, rd_byte;
  logic       prev_scl, prev_d;

  assign sda_line   = ~sda_oe & resp_rel;
  assign sda_line63 = ~sda_oe63 & rel63;

  always #5 clk = ~clk;

  sccb_reader #(.QUARTER(4), .DEV_ID(8'h42)) dut (
    .clk_25M(clk), .rst(rst), .start(start), .reg_addr(reg_addr), .sda_i(sda_line),
    .sda_oe(sda_oe), .scl(scl), .ready(ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .ack_err(ack_err)
  );

  sccb_reader dut63 (
    .clk_25M(clk), .rst(rst), .start(start63), .reg_addr(reg_addr63), .sda_i(sda_line63),
    .sda_oe(sda_oe63), .scl(scl63), .ready(ready63), .rd_data(rd_data63),
    .rd_valid(rd_valid63), .ack_err(ack_err63)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model: watches SCL/SDA for START, STOP and bits, ACKs writes, serves reads.
  initial begin
    resp_rel = 1'b1; prev_scl = 1'b1; prev_d = 1'b1;
    bit_pos = 0; byte_in_frame = 0; frame_read = 0;
    cur_byte = '0; last_addr = '0; rd_byte = '0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        resp_rel = 1'b1; bit_pos = 0; byte_in_frame = 0; frame_read = 0;
        prev_scl = 1'b1; prev_d = 1'b1;
      end else begin
        if (prev_scl && scl && prev_d && !sda_line) begin
          n_start++; bit_pos = 0; byte_in_frame = 0; frame_read = 0;
        end else if (prev_scl && scl && !prev_d && sda_line) begin
          n_stop++;
        end else if (!prev_scl && scl) begin
          if (bit_pos < 8) cur_byte = {cur_byte[6:0], sda_line};
          bit_pos++;
          if (bit_pos == 9) begin
            got.push_back(cur_byte);
            if (byte_in_frame == 0) begin
              frame_read = cur_byte[0];
              rd_byte    = reg_file[last_addr];
            end else if (!frame_read) begin
              last_addr = cur_byte;
            end
            byte_in_frame++;
            bit_pos = 0;
          end
        end else if (prev_scl && !scl) begin
          if (bit_pos == 8) begin
            if (frame_read && byte_in_frame >= 1) resp_rel = 1'b1;
            else resp_rel = (got.size() == nack_idx) ? 1'b1 : 1'b0;
          end else if (frame_read && byte_in_frame == 1) begin
            resp_rel = rd_byte[7 - bit_pos];
          end else begin
            resp_rel = 1'b1;
          end
        end
        prev_scl = scl;
        prev_d   = sda_line;
      end
    end
  end

  // One read on the QUARTER=4 instance; optional ignored start pulses or a mid-flight reset.
  task automatic apply_stimulus(input logic [7:0] addr, input int nack, input bit pulses,
                                input int rst_at, input string tag);
    int  nvalid, vcyc, early_ready;
    bit  aborted;
    nvalid = 0; vcyc = -1; early_ready = 0; aborted = 0;
    @(negedge clk);
    got.delete(); n_start = 0; n_stop = 0; nack_idx = nack;
    start = 1'b1; reg_addr = addr;
    @(posedge clk);
    #1 start = 1'b0; reg_addr = 8'($urandom);
    for (int i = 1; i <= 640; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check_output({tag, "_ready_lo"}, ready, 1'b0);
        check_output({tag, "_ackerr_clr"}, ack_err, 1'b0);
      end
      start = (pulses && (i == 10 || i == 300)) ? 1'b1 : 1'b0;
      if (rst_at > 0 && i == rst_at) rst = 1'b1;
      if (rst_at > 0 && i == rst_at + 1) begin
        check_output({tag, "_rst_bus"}, {scl, sda_oe, ready, rd_valid}, 4'b1010);
        rst = 1'b0;
        aborted = 1;
        break;
      end
      if (rd_valid) begin nvalid++; vcyc = i; end
      if (i < 633 && ready) early_ready++;
      if (i == 633) check_output({tag, "_ready_done"}, ready, 1'b1);
    end
    if (!aborted) begin
      check_output({tag, "_nvalid"}, nvalid, 1);
      check_output({tag, "_vcyc"}, vcyc, 633);
      check_output({tag, "_busy"}, early_ready, 0);
      check_output({tag, "_rd_data"}, rd_data, reg_file[addr]);
      check_output({tag, "_ack_err"}, ack_err, (nack >= 0 && nack <= 2) ? 1 : 0);
      check_output({tag, "_nbytes"}, got.size(), 4);
      if (got.size() == 4) begin
        check_output({tag, "_b0"}, got[0], 8'h42);
        check_output({tag, "_b1"}, got[1], addr);
        check_output({tag, "_b2"}, got[2], 8'h43);
        check_output({tag, "_b3"}, got[3], reg_file[addr]);
      end
      check_output({tag, "_starts"}, n_start, 2);
      check_output({tag, "_stops"}, n_stop, 2);
    end
  endtask

  initial begin
    int nv, c1, c2, r_after;
    logic [7:0] d1, d2;
    logic e1, e2;
    for (int i = 0; i < 256; i++) reg_file[i] = 8'($urandom_range(0, 255));
    reg_file[8'h12] = 8'hA5;
    rst = 1'b1; start = 1'b0; start63 = 1'b0; reg_addr = '0; reg_addr63 = 8'h0A;
    rel63 = 1'b0; nack_idx = -1; n_start = 0; n_stop = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_state", {scl, sda_oe, ready, rd_valid, rd_data, ack_err}, {4'b1010, 8'h00, 1'b0});
    check_output("reset_state63", {scl63, sda_oe63, ready63, rd_valid63, rd_data63}, {4'b1010, 8'h00});
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_output("idle", {scl, sda_oe, ready, rd_valid, rd_data}, {4'b1010, 8'h00});
    end

    $display("[TB] read of 0x12");
    apply_stimulus(8'h12, -1, 0, 0, "rd12");
    $display("[TB] address byte left unacknowledged");
    apply_stimulus(8'h12, 1, 0, 0, "nack");
    apply_stimulus(8'($urandom), -1, 0, 0, "rand1");
    $display("[TB] start pulses while busy");
    apply_stimulus(8'($urandom), -1, 1, 0, "ignore");
    $display("[TB] reset during address byte");
    apply_stimulus(8'h12, -1, 0, 200, "abort");
    apply_stimulus(8'($urandom), -1, 0, 0, "after_rst");
    apply_stimulus(8'($urandom), 2, 0, 0, "nack_idr");

    $display("[TB] back-to-back at default QUARTER");
    nv = 0; c1 = -1; c2 = -1; r_after = -1; d1 = '0; d2 = '0; e1 = 1'bx; e2 = 1'bx;
    @(negedge clk);
    start63 = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 19912; i++) begin
      @(negedge clk);
      if (rd_valid63) begin
        nv++;
        if (nv == 1) begin c1 = i; d1 = rd_data63; e1 = ack_err63; end
        else if (nv == 2) begin c2 = i; d2 = rd_data63; e2 = ack_err63; end
      end
      if (i == 9955) rel63 = 1'b1;
      if (i == 9956) r_after = int'(ready63);
    end
    start63 = 1'b0;
    check_output("b2b_nvalid", nv, 2);
    check_output("b2b_c1", c1, 9955);
    check_output("b2b_d1", d1, 8'h00);
    check_output("b2b_e1", e1, 1'b0);
    check_output("b2b_restart", r_after, 0);
    check_output("b2b_c2", c2, 19910);
    check_output("b2b_d2", d2, 8'hFF);
    check_output("b2b_e2", e2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sccb_reader.md
Name: sccb_reader

Overview:
- SCCB read-back master for the OV7670 control bus. It issues a 3-phase write to set the sub-address, then a 2-phase read, and returns the register byte.
- It sits beside the existing SCCB write path so that the config logic and keypad debug can verify programmed camera registers.
- Runs on clk_25M and drives SCL push-pull. SDA is open-drain through an enable, with the input sampled back.

Parameters:
- QUARTER, 63: clk_25M cycles per quarter SCL period (63 gives 252 cycles per bit, about 99.2 kHz). Legal range is 2..255.
- DEV_ID, 8'h42: 7-bit device ID plus write bit (bit0 = 0). The read phase sends DEV_ID | 8'h01.

Ports:
- clk_25M  in  1  system clock, 25 MHz.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a read; sampled only while ready=1.
- reg_addr  in  8  camera register address; latched on an accepted start.
- sda_i  in  1  SDA pad input (already synchronised externally).
- sda_oe  out  1  1 = pull SDA low; 0 = release (pull-up gives high).
- scl  out  1  SCCB clock.
- ready  out  1  1 = idle and able to accept start.
- rd_data  out  8  last byte read; held until the next completion.
- rd_valid  out  1  one-cycle pulse when rd_data updates.
- ack_err  out  1  set if any write-phase 9th bit was sampled high; cleared on an accepted start.

Behaviour:
- Reset (rst=1 at a clk_25M edge): scl=1, sda_oe=0, ready=1, rd_valid=0, rd_data=8'h00, ack_err=0, state=IDLE, counters=0.
- Reset mid-transaction aborts immediately. No STOP is generated. The bus is released on the next edge.
- Timebase: a quarter counter runs 0..QUARTER-1. It wraps and advances the sequencer one quarter per wrap. It is held at 0 in IDLE.
- Accepted start: start=1 and ready=1 at cycle 0.
  - Latch reg_addr, clear ack_err, set ready=0.
  - The first quarter begins at cycle 1.
- start while ready=0 is ignored (not queued).
- Sequencer states: IDLE -> START1 -> TX_IDW -> TX_ADDR -> STOP1 -> BUS_FREE -> START2 -> TX_IDR -> RX_DATA -> STOP2 -> IDLE.
- START (2 quarters):
  - q0: scl=1, sda_oe=0.
  - q1: scl=1, sda_oe=1.
- Bit slot (4 quarters):
  - q0/q1: scl=0, SDA set at the start of q0.
  - q2/q3: scl=1.
  - SDA is sampled on the last cycle of q2.
- Byte (9 bit slots):
  - TX: 8 bits MSB first, sda_oe = ~bit. Slot 9 releases SDA (sda_oe=0) and samples the don't-care bit. A sample of 1 sets ack_err (sticky).
  - RX_DATA: slots 1-8 release SDA and shift sda_i into a register MSB first. Slot 9 drives NA (sda_oe=0, high).
- STOP (3 quarters):
  - q0: scl=0, sda_oe=1.
  - q1: scl=1, sda_oe=1.
  - q2: scl=1, sda_oe=0.
- BUS_FREE: 4 quarters with scl=1, sda_oe=0.
- Bytes sent: TX_IDW sends DEV_ID, TX_ADDR sends the latched address, TX_IDR sends DEV_ID|1.
- ack_err does not abort the transaction; the full sequence always completes, so timing is deterministic.
- Total length: 2+36+36+3+4+2+36+36+3 = 158 quarters.
- Completion:
  - At cycle 1+158*QUARTER: rd_data <= shift register, rd_valid=1 for one cycle, ready=1, state=IDLE.
  - A start at this same cycle is accepted, and the next transaction begins the following cycle.
- Outside START/STOP windows, SDA changes only while scl=0.

Test Plan:
- Reset, then idle for 100 cycles -> scl=1, sda_oe=0, ready=1, rd_valid=0, rd_data=8'h00 throughout.
- QUARTER=4, responder model ACKs low and returns 8'hA5 for reg_addr=8'h12 -> correct waveform:
  - decoded bytes 42, 12, 43;
  - rd_valid only at cycle 633 with rd_data=8'hA5;
  - ready=1 from cycle 633;
  - ack_err=0.
- Same stimulus, but the responder leaves the TX_ADDR 9th bit high -> transaction still completes at cycle 633 and ack_err=1. The next start clears ack_err in the accept cycle.
- start pulsed at cycles 10 and 300 during a transaction (QUARTER=4) -> ignored: exactly one rd_valid, at cycle 633.
- rst asserted at cycle 200 during TX_ADDR -> next cycle scl=1, sda_oe=0, ready=1. A new start then yields a normal 633-cycle transaction.
- Back-to-back: start held high, reads return 8'h00 then 8'hFF -> the second transaction starts the cycle after the first completion, and rd_data goes 00 then FF. Default QUARTER=63 gives the first rd_valid at cycle 9955.
